// File: rtl/reset_sequencer.sv
// Reset and bring-up controller: syncs PLL lock and the user button, debounces the
// button, then releases a vector of staged resets in ascending order once lock is stable.
module reset_sequencer #(
  parameter int unsigned CHANNELS          = 4,
  parameter int unsigned POR_CYCLES        = 1024,
  parameter int unsigned STAGE_CYCLES      = 16,
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b0,
  parameter int unsigned COUNT_WIDTH       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   button,
  output logic [CHANNELS-1:0]    reset_out,
  output logic                   ready,
  output logic [COUNT_WIDTH-1:0] abort_count
);

  localparam int unsigned PorW = $clog2(POR_CYCLES + 1);
  localparam int unsigned StgW = $clog2(STAGE_CYCLES + 1);
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IdxW = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

  state_e                 state_q, state_d;
  logic                   lock_meta_q, lock_sync_q;
  logic                   btn_meta_q, btn_sync_q;
  logic                   btn_deb_q, btn_deb_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d, db_inc;
  logic [PorW-1:0]        por_q, por_d, por_inc;
  logic [StgW-1:0]        stg_q, stg_d, stg_inc;
  logic [IdxW-1:0]        idx_q, idx_d, idx_inc;
  logic [CHANNELS-1:0]    reset_out_q, reset_out_d;
  logic                   ready_q, ready_d;
  logic [COUNT_WIDTH-1:0] abort_q, abort_d;
  logic                   btn_in;
  logic                   abort_req;

  assign btn_in    = button ^ BUTTON_ACTIVE_LOW;
  assign db_inc    = db_cnt_q + DbW'(1);
  assign por_inc   = por_q + PorW'(1);
  assign stg_inc   = stg_q + StgW'(1);
  assign idx_inc   = idx_q + IdxW'(1);
  assign abort_req = !lock_sync_q || btn_deb_q;

  // Debouncer: the level flips only after a full run of consecutive differing samples.
  always_comb begin
    btn_deb_d = btn_deb_q;
    db_cnt_d  = '0;
    if (btn_sync_q != btn_deb_q) begin
      if (db_inc == DbW'(DEBOUNCE_CYCLES)) begin
        btn_deb_d = ~btn_deb_q;
      end else begin
        db_cnt_d = db_inc;
      end
    end
  end

  // Sequencer next state; abort wins over any release due on the same edge.
  always_comb begin
    state_d     = state_q;
    por_d       = '0;
    stg_d       = stg_q;
    idx_d       = idx_q;
    reset_out_d = reset_out_q;
    ready_d     = ready_q;
    abort_d     = abort_q;
    unique case (state_q)
      StHold: begin
        reset_out_d = '1;
        ready_d     = 1'b0;
        if (lock_sync_q && !btn_deb_q) begin
          if (por_inc == PorW'(POR_CYCLES)) begin
            state_d     = StRelease;
            reset_out_d = ~CHANNELS'(1);
            stg_d       = '0;
            idx_d       = '0;
          end else begin
            por_d = por_inc;
          end
        end
      end
      StRelease, StRun: begin
        if (abort_req) begin
          state_d     = StHold;
          reset_out_d = '1;
          ready_d     = 1'b0;
          abort_d     = (abort_q == '1) ? abort_q : abort_q + COUNT_WIDTH'(1);
        end else if (state_q == StRun) begin
          reset_out_d = '0;
          ready_d     = 1'b1;
        end else if (stg_inc == StgW'(STAGE_CYCLES)) begin
          stg_d = '0;
          idx_d = idx_inc;
          if (idx_inc == IdxW'(CHANNELS)) begin
            state_d     = StRun;
            reset_out_d = '0;
            ready_d     = 1'b1;
          end else begin
            reset_out_d = reset_out_q & ~(CHANNELS'(1) << idx_inc);
          end
        end else begin
          stg_d = stg_inc;
        end
      end
      default: begin
        state_d     = StHold;
        reset_out_d = '1;
        ready_d     = 1'b0;
      end
    endcase
  end

  // State, synchronisers, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StHold;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_deb_q   <= 1'b0;
      db_cnt_q    <= '0;
      por_q       <= '0;
      stg_q       <= '0;
      idx_q       <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
      abort_q     <= '0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
      btn_meta_q  <= btn_in;
      btn_sync_q  <= btn_meta_q;
      btn_deb_q   <= btn_deb_d;
      db_cnt_q    <= db_cnt_d;
      por_q       <= por_d;
      stg_q       <= stg_d;
      idx_q       <= idx_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
      abort_q     <= abort_d;
    end
  end

  assign reset_out   = reset_out_q;
  assign ready       = ready_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a per-edge vector table plus a saturation sequence.
module tb_reset_sequencer;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       locked = 1'b0;
  logic       button = 1'b0;
  logic [2:0] reset_out;
  logic       ready;
  logic [1:0] abort_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .CHANNELS         (3),
    .POR_CYCLES       (8),
    .STAGE_CYCLES     (2),
    .DEBOUNCE_CYCLES  (4),
    .BUTTON_ACTIVE_LOW(1'b0),
    .COUNT_WIDTH      (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .button     (button),
    .reset_out  (reset_out),
    .ready      (ready),
    .abort_count(abort_count)
  );

  typedef struct {
    int         ph;
    logic       rst;
    logic       lk;
    logic       bt;
    logic [2:0] ro;
    logic       rdy;
    logic [1:0] ac;
  } vec_t;

  vec_t vecs[$];

  // Outputs of one bring-up attempt n edges in, bit i released at base+2i, ready at base+6.
  function automatic logic [3:0] attempt(int n, int base);
    logic [3:0] r;
    r[3] = (n >= base + 6);
    for (int i = 0; i < 3; i++) r[i] = !(n >= base + 2 * i);
    return r;
  endfunction

  // Attempt with base b0 until the abort edge ab, then a fresh attempt with base b1.
  function automatic logic [3:0] model(int n, int b0, int ab, int b1);
    return (n < ab) ? attempt(n, b0) : attempt(n, b1);
  endfunction

  function automatic string ph_name(int ph);
    case (ph)
      0: return "reset";
      1: return "bringup";
      2: return "lock_loss";
      3: return "btn_short";
      4: return "btn_long";
      5: return "reset_midop";
      6: return "abort_midrel";
      default: return "saturation";
    endcase
  endfunction

  task automatic push(input int ph, input logic rst, input logic lk, input logic bt,
                      input logic [3:0] m, input logic [1:0] ac);
    vec_t v;
    v.ph = ph; v.rst = rst; v.lk = lk; v.bt = bt;
    v.ro = m[2:0]; v.rdy = m[3]; v.ac = ac;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic lk, input logic bt);
    reset  = rst;
    locked = lk;
    button = bt;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input int ph, input int n, input logic [2:0] ro, input logic rdy,
                       input logic [1:0] ac);
    total += 3;
    if (reset_out !== ro) begin
      bad++;
      $display("FAIL %s[%0d] reset_out got %b want %b", ph_name(ph), n, reset_out, ro);
    end
    if (ready !== rdy) begin
      bad++;
      $display("FAIL %s[%0d] ready got %b want %b", ph_name(ph), n, ready, rdy);
    end
    if (abort_count !== ac) begin
      bad++;
      $display("FAIL %s[%0d] abort_count got %0d want %0d", ph_name(ph), n, abort_count, ac);
    end
  endtask

  initial begin
    logic [3:0] m;
    logic [1:0] exp_ac;

    // Reset, then normal bring-up: bits clear at edges 10/12/14, ready at 16.
    push(0, 1'b1, 1'b1, 1'b0, 4'b0111, 2'd0);
    for (int n = 1; n <= 17; n++) push(1, 1'b0, 1'b1, 1'b0, model(n, 0, 0, 10), 2'd0);
    // One-cycle lock drop in RUN: abort 3 edges later, sequence repeats.
    for (int n = 1; n <= 18; n++)
      push(2, 1'b0, n != 1, 1'b0, model(n, -100, 3, 11), (n >= 3) ? 2'd1 : 2'd0);
    // 3-cycle button glitch: no effect.
    for (int n = 1; n <= 10; n++) push(3, 1'b0, 1'b1, n <= 3, attempt(n, -100), 2'd1);
    // 6-cycle press: abort at edge 7, restart after debounced release plus POR.
    for (int n = 1; n <= 21; n++)
      push(4, 1'b0, 1'b1, n <= 6, model(n, -100, 7, 20), (n >= 7) ? 2'd2 : 2'd1);
    // Reset while in RELEASE with abort_count=2.
    push(5, 1'b1, 1'b1, 1'b0, 4'b0111, 2'd0);
    // Lock pin drops as bit 0 clears: abort at edge 12 beats the bit 1 release.
    for (int n = 1; n <= 29; n++)
      push(6, 1'b0, !(n >= 10 && n <= 12), 1'b0, model(n, 10, 12, 22),
           (n >= 12) ? 2'd1 : 2'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].lk, vecs[k].bt);
      check(vecs[k].ph, k, vecs[k].ro, vecs[k].rdy, vecs[k].ac);
    end

    // Saturation: five aborts from RUN read 1, 2, 3, 3, 3.
    step(1'b1, 1'b1, 1'b0);
    check(7, 0, 3'b111, 1'b0, 2'd0);
    for (int n = 1; n <= 16; n++) begin
      step(1'b0, 1'b1, 1'b0);
      m = attempt(n, 10);
      check(7, n, m[2:0], m[3], 2'd0);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_ac = (k < 3) ? 2'(k) : 2'd3;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check(7, 100 * k, 3'b111, 1'b0, exp_ac);
      for (int n = 4; n <= 17; n++) begin
        step(1'b0, 1'b1, 1'b0);
        m = attempt(n, 11);
        if (n == 17 || n == 11) check(7, 100 * k + n, m[2:0], m[3], exp_ac);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset and bring-up controller that sits directly behind the board PLL in the top level. It synchronises the PLL lock flag and a user reset button, then debounces the button. It holds a vector of per-subsystem resets asserted until the clocks are stable, then releases them one by one in a fixed order and reports readiness. Any loss of lock or any button press re-enters the hold state and restarts the sequence.

## Interface
- CHANNELS, 4: number of staged reset outputs, 1..16
- POR_CYCLES, 1024: cycles of stable lock with the button released before release starts, ≥1
- STAGE_CYCLES, 16: gap in cycles between consecutive channel releases, ≥1
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to change the debounced button level, ≥1
- BUTTON_ACTIVE_LOW, 0: 1 inverts `button` before synchronisation
- COUNT_WIDTH, 8: width of `abort_count`
- clock  in  1  the single system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high global reset
- locked  in  1  PLL lock, asynchronous to `clock`
- button  in  1  user reset request, asynchronous, bouncing
- reset_out  out  CHANNELS  per-subsystem resets, active-high
- ready  out  1  high once every channel has been released
- abort_count  out  COUNT_WIDTH  number of sequence aborts, saturating

## Operation
- Input conditioning:
  - `locked` and the polarity-corrected `button` each pass through a 2-flop synchroniser.
  - The debouncer tracks how long the synchronised button has differed from the debounced level. The debounced level flips only after DEBOUNCE_CYCLES consecutive differing cycles. Any agreeing cycle clears the count.
- FSM states: HOLD, RELEASE, RUN.
- HOLD:
  - All `reset_out` = 1 and `ready` = 0.
  - The POR counter increments each cycle that lock_sync=1 and the debounced button is 0. It clears to 0 on any other cycle.
  - On the edge where the counter reaches POR_CYCLES, the FSM enters RELEASE, `reset_out[0]` clears, and the stage counter and channel index are both set to 0.
- RELEASE:
  - The stage counter counts to STAGE_CYCLES. On that edge the channel index increments, and `reset_out[index]` clears if the index is less than CHANNELS.
  - When the index reaches CHANNELS, the FSM enters RUN and `ready` is set to 1.
  - Channels release in ascending order, 0 first. A released channel never re-asserts except through HOLD.
- RUN: holds all `reset_out` = 0 and `ready` = 1.
- Abort:
  - In RELEASE or RUN, if lock_sync=0 or the debounced button is 1, the FSM enters HOLD on the next edge.
  - On that same edge all `reset_out` are set to 1, `ready` goes to 0, and `abort_count` increments, saturating at 2^COUNT_WIDTH−1.
  - Abort takes priority over a release scheduled on the same edge.
- Entering HOLD from reset does not count as an abort.
- `reset` = 1 sets, on the next edge:
  - state HOLD;
  - `reset_out` all 1s, `ready` 0, `abort_count` 0;
  - synchroniser flops, debounced level and all counters to 0.

## Timing
- Outputs are registered. No combinational path runs from any input to any output.
- The lock path takes 2 synchroniser edges, and the POR counter needs POR_CYCLES more. This follows from the two-flop synchroniser plus the counter threshold; any change to either stage or its comparison must be reconciled with these edge numbers.
- With `locked`=1 and `button` inactive from the first cycle after `reset` falls, counting that edge as edge 1:
  - `reset_out[i]` falls at edge 2+POR_CYCLES+i·STAGE_CYCLES;
  - `ready` rises at edge 2+POR_CYCLES+CHANNELS·STAGE_CYCLES.
- The debounced button changes DEBOUNCE_CYCLES edges after the synchronised level changes. That is 2+DEBOUNCE_CYCLES edges after the input changes.
- Abort latency, from a change at the input pin to `reset_out` all asserted:
  - `locked` fall: 3 edges;
  - button press: 3+DEBOUNCE_CYCLES edges.
- Glitches on `button` shorter than DEBOUNCE_CYCLES synchronised cycles have no effect.
- `locked` has no filter: a single-cycle drop that the synchroniser samples causes an abort.

## Test plan
All scenarios use CHANNELS=3, POR_CYCLES=8, STAGE_CYCLES=2, DEBOUNCE_CYCLES=4 and BUTTON_ACTIVE_LOW=0.

- **Normal bring-up:** `reset` pulsed, then `locked`=1 and `button`=0 held → `reset_out` = 3'b111 until edge 10. Bits clear at edges 10, 12 and 14 (bit 0, then 1, then 2). `ready` rises at edge 16. `abort_count` stays 0.
- **Lock loss in RUN:** `locked` dropped for 1 cycle → 3 edges later `reset_out`=3'b111, `ready`=0, `abort_count`=1. The full sequence then repeats with the same spacing.
- **Button debounce:** a 3-cycle `button` pulse in RUN → no change. A 6-cycle pulse → abort at edge 7 after the press, `abort_count` increments. Release restarts only after the debounced button returns to 0 and 8 POR cycles elapse.
- **Abort mid-release:** `locked` dropped right after bit 0 clears → bits 1 and 2 are never released, all bits reassert, and `ready` never rises during that attempt.
- **Reset mid-operation:** `reset` asserted during RELEASE with `abort_count`=2 → next edge gives `reset_out`=3'b111, `ready`=0, `abort_count`=0, and the bring-up timing restarts from edge 1.
- **Saturation:** with COUNT_WIDTH=2, force 5 aborts → `abort_count` reads 1, 2, 3, 3, 3.
